// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared types and constants for the SPI TX sequencer.
//   spi_seq_state_t  - sequencer FSM states
//   REQ_*            - request codes driven on req to spi_top
//   spi_seq_entry_t  - command entry layout {mode, data} at the default transfer width
//   mode_done()      - completion rule for a request code given the seen flags

package spi_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ACTIVE,
    GAP
  } spi_seq_state_t;

  localparam logic [1:0] REQ_NONE = 2'd0;
  localparam logic [1:0] REQ_MOSI = 2'd1;
  localparam logic [1:0] REQ_MISO = 2'd2;
  localparam logic [1:0] REQ_FDX  = 2'd3;

  localparam int unsigned SEQ_TRF_BIT = 8;

  typedef struct packed {
    logic [1:0]             mode;
    logic [SEQ_TRF_BIT-1:0] data;
  } spi_seq_entry_t;

  // A transaction ends once every direction its mode uses has reported completion.
  function automatic logic mode_done(input logic [1:0] mode, input logic tx_seen,
                                     input logic rx_seen);
    logic done;
    unique case (mode)
      REQ_MOSI: done = tx_seen;
      REQ_MISO: done = rx_seen;
      REQ_FDX:  done = tx_seen & rx_seen;
      default:  done = 1'b0;
    endcase
    return done;
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// spi_seq_fifo: synchronous FIFO holding sequencer command entries.
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, wdata  - write request and entry; ignored while full
//   pop          - drop the head entry; ignored while empty
//   rdata        - head entry (valid when not empty)
//   full, empty  - occupancy flags

module spi_seq_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_sequencer.sv
// spi_tx_sequencer: buffers host byte commands and issues them one at a time to spi_top.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_mode - host command stream (mode 1 MOSI, 2 MISO, 3 FDX, 0 illegal)
//   master_idle, done_tx, done_rx, dout_master - status from the SPI master
//   req, din_master, wait_duration - request to spi_top
//   busy                       - FSM not in IDLE
//   err                        - one-cycle pulse when a mode-0 entry is dropped
//   rx_valid, rx_data          - captured receive byte
// Build option: define SPI_SEQ_RX_CAPTURE_EN to build the receive capture register;
// otherwise rx_valid/rx_data are tied to 0.

module spi_tx_sequencer #(
  parameter int unsigned SPI_TRF_BIT   = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter int unsigned WAIT_DURATION = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SPI_TRF_BIT-1:0] s_data,
  input  logic [1:0]             s_mode,
  input  logic                   master_idle,
  input  logic                   done_tx,
  input  logic                   done_rx,
  input  logic [SPI_TRF_BIT-1:0] dout_master,
  output logic [1:0]             req,
  output logic [SPI_TRF_BIT-1:0] din_master,
  output logic [7:0]             wait_duration,
  output logic                   busy,
  output logic                   err,
  output logic                   rx_valid,
  output logic [SPI_TRF_BIT-1:0] rx_data
);

  import spi_seq_pkg::*;

  localparam int unsigned GapW   = $clog2(GAP_CYCLES + 1);
  localparam int unsigned EntryW = SPI_TRF_BIT + 2;

  spi_seq_state_t         state_q, state_d;
  logic [1:0]             req_q, req_d;
  logic [SPI_TRF_BIT-1:0] din_q, din_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic                   tx_seen_q, tx_seen_d;
  logic                   rx_seen_q, rx_seen_d;
  logic                   err_q, err_d;
  logic                   done_tx_q, done_rx_q;
  logic                   tx_rise, rx_rise;

  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0]      fifo_head;
  logic [1:0]             head_mode;
  logic [SPI_TRF_BIT-1:0] head_data;

  spi_seq_fifo #(
    .WIDTH (EntryW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .wdata ({s_mode, s_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_mode = fifo_head[SPI_TRF_BIT +: 2];
  assign head_data = fifo_head[SPI_TRF_BIT-1:0];

  // Edges are taken against last cycle's copy so a level held high counts once.
  assign tx_rise = done_tx && !done_tx_q;
  assign rx_rise = done_rx && !done_rx_q;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    din_d     = din_q;
    gap_d     = gap_q;
    tx_seen_d = tx_seen_q;
    rx_seen_d = rx_seen_q;
    err_d     = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && master_idle) state_d = LOAD;
      end
      LOAD: begin
        if (head_mode == REQ_NONE) begin
          fifo_pop = 1'b1;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          req_d     = head_mode;
          din_d     = head_data;
          tx_seen_d = 1'b0;
          rx_seen_d = 1'b0;
          state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        // Completion is judged on registered flags, so req drops the cycle after the edge.
        if (mode_done(req_q, tx_seen_q, rx_seen_q)) begin
          fifo_pop = 1'b1;
          req_d    = REQ_NONE;
          gap_d    = GapW'(GAP_CYCLES - 1);
          state_d  = GAP;
        end else begin
          if (tx_rise) tx_seen_d = 1'b1;
          if (rx_rise) rx_seen_d = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= REQ_NONE;
      din_q     <= '0;
      gap_q     <= '0;
      tx_seen_q <= 1'b0;
      rx_seen_q <= 1'b0;
      err_q     <= 1'b0;
      done_tx_q <= 1'b0;
      done_rx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      din_q     <= din_d;
      gap_q     <= gap_d;
      tx_seen_q <= tx_seen_d;
      rx_seen_q <= rx_seen_d;
      err_q     <= err_d;
      done_tx_q <= done_tx;
      done_rx_q <= done_rx;
    end
  end

  assign s_ready       = !fifo_full;
  assign req           = req_q;
  assign din_master    = din_q;
  assign wait_duration = 8'(WAIT_DURATION);
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

`ifdef SPI_SEQ_RX_CAPTURE_EN
  logic                   rx_capture;
  logic                   rx_valid_q;
  logic [SPI_TRF_BIT-1:0] rx_data_q;

  assign rx_capture = (state_q == ACTIVE) && rx_rise &&
                      ((req_q == REQ_MISO) || (req_q == REQ_FDX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= rx_capture;
      if (rx_capture) rx_data_q <= dout_master;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`else
  logic unused_dout;
  assign unused_dout = ^dout_master;
  assign rx_valid    = 1'b0;
  assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_tx_sequencer.sv
module tb_spi_tx_sequencer;

  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 4;
  localparam int unsigned WAITD = 10;

`ifdef SPI_SEQ_RX_CAPTURE_EN
  localparam bit RxEn = 1'b1;
`else
  localparam bit RxEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic [1:0]   s_mode;
  logic         master_idle;
  logic         done_tx;
  logic         done_rx;
  logic [W-1:0] dout_master;
  logic [1:0]   req;
  logic [W-1:0] din_master;
  logic [7:0]   wait_duration;
  logic         busy;
  logic         err;
  logic         rx_valid;
  logic [W-1:0] rx_data;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  int rx_cnt  = 0;

  // Reference model: entries the DUT has accepted and not yet retired, in order.
  logic [W+1:0] model_q[$];
  logic [W-1:0] last_din;

  spi_tx_sequencer #(
    .SPI_TRF_BIT   (W),
    .FIFO_DEPTH    (DEPTH),
    .GAP_CYCLES    (GAP),
    .WAIT_DURATION (WAITD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_mode        (s_mode),
    .master_idle   (master_idle),
    .done_tx       (done_tx),
    .done_rx       (done_rx),
    .dout_master   (dout_master),
    .req           (req),
    .din_master    (din_master),
    .wait_duration (wait_duration),
    .busy          (busy),
    .err           (err),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err)      err_cnt <= err_cnt + 1;
    if (rx_valid) rx_cnt  <= rx_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one command; the model accepts it only if there is room.
  task automatic push_entry(input logic [1:0] m, input logic [W-1:0] d);
    s_mode  = m;
    s_data  = d;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back({m, d});
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (req === 2'd0 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
  endtask

  // Raise the done lines required by mode m; the last rising edge lands on the tick.
  task automatic complete(input logic [1:0] m, input bit split);
    if (m == 2'd3 && split) begin
      done_tx = 1'b1;
      tick();
      done_tx = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      done_rx = 1'b1;
      tick();
      done_rx = 1'b0;
    end else begin
      done_tx = (m == 2'd1) || (m == 2'd3);
      done_rx = (m == 2'd2) || (m == 2'd3);
      tick();
      done_tx = 1'b0;
      done_rx = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    s_mode      = '0;
    master_idle = 1'b1;
    done_tx     = 1'b0;
    done_rx     = 1'b0;
    dout_master = '0;
    last_din    = '0;
    #22;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (req !== 2'd0) begin bad++; $display("FAIL reset_req got=%0d exp=0", req); end
    total++; if (din_master !== 8'h00) begin bad++; $display("FAIL reset_din got=%h exp=00", din_master); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    total++;
    if (wait_duration !== 8'(WAITD)) begin
      bad++; $display("FAIL wait_duration got=%0d exp=%0d", wait_duration, WAITD);
    end
  endtask

  task automatic test_single();
    logic [W+1:0] exp;
    logic [W-1:0] d;
    for (int i = 0; i < 3; i++) begin
      d = (i == 0) ? 8'hA5 : 8'($urandom);
      push_entry(2'd1, d);
      exp = model_q[0];
      total++; if (req !== 2'd0) begin bad++; $display("FAIL single_req_early got=%0d exp=0", req); end
      tick();
      total++; if (req !== 2'd0) begin bad++; $display("FAIL single_req_n1 got=%0d exp=0", req); end
      tick();
      total++;
      if (req !== exp[W+1:W]) begin bad++; $display("FAIL single_req got=%0d exp=%0d", req, exp[W+1:W]); end
      total++;
      if (din_master !== exp[W-1:0]) begin
        bad++; $display("FAIL single_din got=%h exp=%h", din_master, exp[W-1:0]);
      end
      repeat ($urandom_range(0, 4)) begin
        tick();
        total++; if (req !== 2'd1) begin bad++; $display("FAIL single_hold got=%0d exp=1", req); end
      end
      complete(2'd1, 1'b0);
      total++; if (req !== 2'd1) begin bad++; $display("FAIL single_req_at_done got=%0d exp=1", req); end
      tick();
      total++; if (req !== 2'd0) begin bad++; $display("FAIL single_req_after_done got=%0d exp=0", req); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_gap0 got=%b exp=1", busy); end
      void'(model_q.pop_front());
      last_din = exp[W-1:0];
      for (int k = 1; k < GAP; k++) begin
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_gap%0d got=%b exp=1", k, busy); end
      end
      tick();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
      total++;
      if (din_master !== last_din) begin bad++; $display("FAIL single_din_kept got=%h exp=%h", din_master, last_din); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp;
    int n;
    int idx;
    int req_seen;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (s_ready !== (model_q.size() < DEPTH)) begin
        bad++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, s_ready);
      end
      push_entry(2'($urandom_range(1, 3)), 8'($urandom));
    end
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", s_ready); end
    push_entry(2'd1, 8'h77);
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL b2b_still_full got=%b exp=0", s_ready); end
    idx = 0;
    while (model_q.size() > 0) begin
      exp = model_q[0];
      wait_req(n);
      total++; if (req === 2'd0) begin bad++; $display("FAIL b2b_timeout idx=%0d got=0 exp=nonzero", idx); end
      if (idx > 0) begin
        total++;
        if (n != GAP + 2) begin bad++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=%0d", idx, n, GAP + 2); end
      end
      total++;
      if (req !== exp[W+1:W]) begin bad++; $display("FAIL b2b_mode idx=%0d got=%0d exp=%0d", idx, req, exp[W+1:W]); end
      total++;
      if (din_master !== exp[W-1:0]) begin
        bad++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", idx, din_master, exp[W-1:0]);
      end
      repeat ($urandom_range(0, 3)) tick();
      complete(exp[W+1:W], 1'($urandom_range(0, 1)));
      tick();
      total++; if (req !== 2'd0) begin bad++; $display("FAIL b2b_done idx=%0d got=%0d exp=0", idx, req); end
      void'(model_q.pop_front());
      last_din = exp[W-1:0];
      if (idx == 0) begin
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_pop got=%b exp=1", s_ready); end
      end
      idx++;
    end
    req_seen = 0;
    repeat (20) begin
      tick();
      if (req !== 2'd0) req_seen++;
    end
    total++; if (req_seen != 0) begin bad++; $display("FAIL b2b_refused_issued got=%0d exp=0", req_seen); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_fdx();
    int n;
    logic [W-1:0] d;
    push_entry(2'd3, 8'h3C);
    wait_req(n);
    total++; if (req !== 2'd3) begin bad++; $display("FAIL fdx_req got=%0d exp=3", req); end
    total++; if (din_master !== 8'h3C) begin bad++; $display("FAIL fdx_din got=%h exp=3c", din_master); end
    done_tx = 1'b1;
    tick();
    done_tx = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (req !== 2'd3) begin bad++; $display("FAIL fdx_tx_only_%0d got=%0d exp=3", k, req); end
    end
    done_rx = 1'b1;
    tick();
    done_rx = 1'b0;
    total++; if (req !== 2'd3) begin bad++; $display("FAIL fdx_at_rx got=%0d exp=3", req); end
    tick();
    total++; if (req !== 2'd0) begin bad++; $display("FAIL fdx_end got=%0d exp=0", req); end
    void'(model_q.pop_front());
    wait_idle(n);
    d = 8'($urandom);
    push_entry(2'd3, d);
    wait_req(n);
    total++; if (din_master !== d) begin bad++; $display("FAIL fdx2_din got=%h exp=%h", din_master, d); end
    complete(2'd3, 1'b0);
    total++; if (req !== 2'd3) begin bad++; $display("FAIL fdx2_at_done got=%0d exp=3", req); end
    tick();
    total++; if (req !== 2'd0) begin bad++; $display("FAIL fdx2_end got=%0d exp=0", req); end
    void'(model_q.pop_front());
    last_din = d;
    wait_idle(n);
  endtask

  task automatic test_rx_capture();
    int n;
    int rx0;
    logic [W-1:0] exp_data;
    exp_data = RxEn ? 8'h5A : 8'h00;
    dout_master = 8'h5A;
    push_entry(2'd2, 8'h00);
    wait_req(n);
    total++; if (req !== 2'd2) begin bad++; $display("FAIL miso_req got=%0d exp=2", req); end
    total++; if (din_master !== 8'h00) begin bad++; $display("FAIL miso_din got=%h exp=00", din_master); end
    done_tx = 1'b1;
    tick();
    done_tx = 1'b0;
    tick();
    tick();
    total++; if (req !== 2'd2) begin bad++; $display("FAIL miso_ignores_tx got=%0d exp=2", req); end
    rx0 = rx_cnt;
    done_rx = 1'b1;
    tick();
    done_rx = 1'b0;
    total++; if (rx_valid !== RxEn) begin bad++; $display("FAIL rx_valid got=%b exp=%b", rx_valid, RxEn); end
    total++; if (rx_data !== exp_data) begin bad++; $display("FAIL rx_data got=%h exp=%h", rx_data, exp_data); end
    dout_master = 8'($urandom);
    tick();
    total++; if (req !== 2'd0) begin bad++; $display("FAIL miso_end got=%0d exp=0", req); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_valid_pulse got=%b exp=0", rx_valid); end
    total++; if (rx_data !== exp_data) begin bad++; $display("FAIL rx_data_held got=%h exp=%h", rx_data, exp_data); end
    total++;
    if (rx_cnt - rx0 != int'(RxEn)) begin
      bad++; $display("FAIL rx_pulse_count got=%0d exp=%0d", rx_cnt - rx0, RxEn);
    end
    void'(model_q.pop_front());
    last_din = 8'h00;
    wait_idle(n);
  endtask

  task automatic test_illegal();
    int n;
    int e0;
    int req_seen;
    logic [W-1:0] d;
    e0 = err_cnt;
    req_seen = 0;
    push_entry(2'd0, 8'hFF);
    repeat (10) begin
      tick();
      if (req !== 2'd0) req_seen++;
    end
    void'(model_q.pop_front());
    total++; if (req_seen != 0) begin bad++; $display("FAIL illegal_req got=%0d exp=0", req_seen); end
    total++; if (err_cnt - e0 != 1) begin bad++; $display("FAIL illegal_err got=%0d exp=1", err_cnt - e0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL illegal_busy got=%b exp=0", busy); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL illegal_ready got=%b exp=1", s_ready); end
    total++;
    if (din_master !== last_din) begin bad++; $display("FAIL illegal_din got=%h exp=%h", din_master, last_din); end
    d = 8'($urandom);
    push_entry(2'd1, d);
    wait_req(n);
    total++; if (n != 2) begin bad++; $display("FAIL illegal_next_latency got=%0d exp=2", n); end
    total++; if (din_master !== d) begin bad++; $display("FAIL illegal_next_din got=%h exp=%h", din_master, d); end
    complete(2'd1, 1'b0);
    tick();
    void'(model_q.pop_front());
    last_din = d;
    wait_idle(n);
  endtask

  task automatic test_random();
    logic [W+1:0] exp;
    int n;
    int hold;
    int req_seen;
    for (int i = 0; i < 8; i++) begin
      hold = $urandom_range(0, 3);
      if (hold > 0) master_idle = 1'b0;
      push_entry(2'($urandom_range(1, 3)), 8'($urandom));
      exp = model_q[0];
      if (hold > 0) begin
        req_seen = 0;
        repeat (hold + 2) begin
          tick();
          if (req !== 2'd0) req_seen++;
        end
        total++; if (req_seen != 0) begin bad++; $display("FAIL rnd_master_busy got=%0d exp=0", req_seen); end
        master_idle = 1'b1;
      end
      wait_req(n);
      total++; if (n != 2) begin bad++; $display("FAIL rnd_latency i=%0d got=%0d exp=2", i, n); end
      total++;
      if (req !== exp[W+1:W]) begin bad++; $display("FAIL rnd_mode i=%0d got=%0d exp=%0d", i, req, exp[W+1:W]); end
      total++;
      if (din_master !== exp[W-1:0]) begin
        bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, din_master, exp[W-1:0]);
      end
      repeat ($urandom_range(0, 5)) tick();
      complete(exp[W+1:W], 1'($urandom_range(0, 1)));
      tick();
      total++; if (req !== 2'd0) begin bad++; $display("FAIL rnd_done i=%0d got=%0d exp=0", i, req); end
      void'(model_q.pop_front());
      last_din = exp[W-1:0];
      wait_idle(n);
      total++; if (n != GAP) begin bad++; $display("FAIL rnd_gap i=%0d got=%0d exp=%0d", i, n, GAP); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int e0;
    int req_seen;
    logic [W-1:0] d;
    e0 = err_cnt;
    push_entry(2'd1, 8'($urandom));
    push_entry(2'd2, 8'($urandom));
    wait_req(n);
    total++; if (req !== 2'd1) begin bad++; $display("FAIL rmid_active got=%0d exp=1", req); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (req !== 2'd0) begin bad++; $display("FAIL rmid_req got=%0d exp=0", req); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    total++; if (din_master !== 8'h00) begin bad++; $display("FAIL rmid_din got=%h exp=00", din_master); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", s_ready); end
    model_q.delete();
    last_din = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req_seen = 0;
    repeat (10) begin
      tick();
      if (req !== 2'd0) req_seen++;
    end
    total++; if (req_seen != 0) begin bad++; $display("FAIL rmid_fifo_empty got=%0d exp=0", req_seen); end
    total++; if (err_cnt != e0) begin bad++; $display("FAIL rmid_err got=%0d exp=%0d", err_cnt, e0); end
    d = 8'($urandom);
    push_entry(2'd1, d);
    wait_req(n);
    total++; if (din_master !== d) begin bad++; $display("FAIL rmid_after_din got=%h exp=%h", din_master, d); end
    complete(2'd1, 1'b0);
    tick();
    total++; if (req !== 2'd0) begin bad++; $display("FAIL rmid_after_done got=%0d exp=0", req); end
    void'(model_q.pop_front());
    wait_idle(n);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fdx();
    test_rx_capture();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_sequencer.md
# spi_tx_sequencer

Upstream command stage for `spi_top`. It buffers byte transactions from a host-side valid/ready stream in a small FIFO and issues them one at a time to the SPI master. For each transaction it drives `req`, `din_master` and `wait_duration`, waits for the matching `done_tx`/`done_rx` completion, then pops the entry and enforces an idle gap before starting the next one.

## Interface
- `SPI_TRF_BIT`, 8: transfer width in bits.
- `FIFO_DEPTH`, 4: number of command entries; must be a power of two and at least 2.
- `GAP_CYCLES`, 4: number of clk cycles `req` is held at 0 between transactions; minimum 1.
- `WAIT_DURATION`, 10: constant value driven on `wait_duration`.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  host command valid.
- `s_ready`  out  1  FIFO can accept a command; equals not-full.
- `s_data`  in  SPI_TRF_BIT  byte to transmit.
- `s_mode`  in  2  request code: 1 = MOSI, 2 = MISO, 3 = full duplex; 0 is illegal.
- `master_idle`  in  1  high when the master TX and RX state machines are both 0.
- `done_tx`  in  1  master TX complete.
- `done_rx`  in  1  master RX complete.
- `dout_master`  in  SPI_TRF_BIT  byte received by the master.
- `req`  out  2  request to `spi_top`.
- `din_master`  out  SPI_TRF_BIT  byte to the master.
- `wait_duration`  out  8  constant `WAIT_DURATION`.
- `busy`  out  1  high whenever the state is not IDLE.
- `err`  out  1  one-cycle pulse when an entry with mode 0 is dropped.
- `rx_valid`  out  1  one-cycle pulse when a received byte is captured (see Configuration).
- `rx_data`  out  SPI_TRF_BIT  received byte.

## Operation
- A push occurs on any clk edge where `s_valid && s_ready`. The entry is {mode, data}. While the FIFO is full, `s_ready` is 0 and the input is ignored.
- State machine states: IDLE, LOAD, ACTIVE, GAP.
- IDLE → LOAD when the FIFO is not empty and `master_idle` is high.
- LOAD, when the head mode is 0:
  - pop the entry and pulse `err`;
  - return to IDLE;
  - `req` stays 0.
- LOAD, otherwise:
  - register `req` = head mode and `din_master` = head data;
  - clear the completion flags `tx_seen` and `rx_seen`;
  - go to ACTIVE.
- ACTIVE:
  - A completion event is a rising edge of `done_tx` or `done_rx`, taken from the previous-cycle registered copy.
  - A rising edge on `done_tx` sets `tx_seen`; a rising edge on `done_rx` sets `rx_seen`.
  - The transaction is complete when: mode 1 has `tx_seen`; mode 2 has `rx_seen`; mode 3 has both.
  - Both edges arriving in the same cycle set both flags.
  - On completion: pop the head, drive `req` to 0, load the gap counter with `GAP_CYCLES-1`, and go to GAP.
- GAP: decrement the counter each cycle; go to IDLE when it reaches 0.
- `din_master` and `req` stay stable for the whole of ACTIVE. `din_master` keeps its last value when not in ACTIVE.
- Push and pop may happen in the same cycle; the occupancy count is then unchanged. A push into a full FIFO coinciding with a pop is still refused, because `s_ready` is computed from the pre-pop count.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. The count is `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- Reset values: `req` = 0, `din_master` = 0, `busy` = 0, `err` = 0, `rx_valid` = 0, `rx_data` = 0, FIFO empty, `s_ready` = 1, state IDLE.
- Latency: a push into an empty FIFO at edge N, with `master_idle` high, gives `req` and `din_master` valid from edge N+2.
- Completion: for a qualifying rising edge of `done_*` sampled at edge M, `req` = 0 from edge M+1.
- The next `req` appears no earlier than M+1+`GAP_CYCLES`+2.
- Reset asserted mid-transaction clears all outputs immediately, with no pop, flush or err pulse.

## Configuration
- `SPI_SEQ_RX_CAPTURE_EN`, when defined:
  - in ACTIVE with mode 2 or 3, a `done_rx` rising edge latches `dout_master` into `rx_data`;
  - `rx_valid` pulses for one cycle at the same time.
- When undefined: `rx_valid` and `rx_data` are tied to 0, and no capture register is built.

## Structure
- Package `spi_seq_pkg` holds:
  - the state enum `spi_seq_state_t` (IDLE, LOAD, ACTIVE, GAP);
  - constants `REQ_MOSI` = 1, `REQ_MISO` = 2, `REQ_FDX` = 3;
  - the entry struct {mode, data}.
- One sub-module, `spi_seq_fifo`: a synchronous FIFO with push/pop, full/empty flags and head read.

## Test plan
- Push {1, 0xA5} into an empty FIFO with `master_idle` = 1, then pulse `done_tx`:
  - `req` = 1 and `din_master` = 0xA5 two cycles after the push;
  - `req` = 0 one cycle after `done_tx`;
  - `busy` stays high for `GAP_CYCLES` cycles after that.
- Push 4 entries back-to-back:
  - `s_ready` = 0 after the 4th push;
  - a 5th `s_valid` is refused;
  - after the first completion, `s_ready` returns to 1 and the entries issue in FIFO order.
- Push {3, 0x3C}:
  - `done_tx` alone does not end the transaction;
  - a `done_rx` pulse 5 cycles later ends it;
  - repeat with both pulses in the same cycle, which ends it the next cycle.
- Push {2, 0x00} with `dout_master` = 0x5A, then pulse `done_rx`:
  - with the macro defined: `rx_valid` pulses once and `rx_data` = 0x5A;
  - without the macro: both stay 0.
- Push {0, 0xFF}: `err` pulses once, `req` never leaves 0, and the FIFO ends empty.
- Assert `rst_n` low during ACTIVE: `req`, `busy` and `din_master` go to 0 asynchronously, and the FIFO is empty after release.
